// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// demux_pkg : shared width and channel-select constants for demux4_16b_buf
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

   localparam int DEMUX_WIDTH = 16;
   localparam int NUM_CH      = 4;

   typedef logic [1:0] ch_sel_t;

   localparam ch_sel_t CH_A = 2'd0;
   localparam ch_sel_t CH_B = 2'd1;
   localparam ch_sel_t CH_C = 2'd2;
   localparam ch_sel_t CH_D = 2'd3;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
//------------------------------------------------------------------------------
// demux_slot : one-entry output buffer with valid/ready drain handshake
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             drain_ready,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             free
);

   logic             full_q;
   logic             full_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             drain;

   assign drain = full_q && drain_ready;

   // A load wins over a drain, which gives the zero-bubble refill.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load) begin
         full_d = 1'b1;
         data_d = din;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign dout  = data_q;
   assign valid = full_q;
   assign free  = !full_q || drain;

endmodule

`default_nettype wire

// File: rtl/demux4_16b_buf.sv
//------------------------------------------------------------------------------
// demux4_16b_buf : registered 1-to-4 demultiplexer with per-channel skid slots.
//                  DEMUX_BROADCAST_EN adds a broadcast input loading all slots.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux4_16b_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] X,
   input  logic [1:0]       control,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef DEMUX_BROADCAST_EN
   input  logic             broadcast,
`endif
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic             A_valid,
   output logic             B_valid,
   output logic             C_valid,
   output logic             D_valid,
   input  logic             A_ready,
   input  logic             B_ready,
   input  logic             C_ready,
   input  logic             D_ready,
   output logic             busy
);

   logic [NUM_CH-1:0] ch_ready;
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH-1:0] ch_free;
   logic [NUM_CH-1:0] ch_load;
   logic [WIDTH-1:0]  ch_data [NUM_CH];
   logic              bcast;

   assign ch_ready = {D_ready, C_ready, B_ready, A_ready};

`ifdef DEMUX_BROADCAST_EN
   assign bcast = broadcast;
`else
   assign bcast = 1'b0;
`endif

   // Broadcast needs every slot able to take the word on this edge.
   assign in_ready = bcast ? (&ch_free) : ch_free[control];

   always_comb begin
      ch_load = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ch_load[k] = in_valid && in_ready && (bcast || (control == 2'(k)));
      end
   end

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_slot
         demux_slot #(
            .WIDTH       (WIDTH)
         ) u_slot (
            .clk         (CLK),
            .rst_n       (RST_N),
            .load        (ch_load[k]),
            .din         (X),
            .drain_ready (ch_ready[k]),
            .dout        (ch_data[k]),
            .valid       (ch_valid[k]),
            .free        (ch_free[k])
         );
      end
   endgenerate

   assign A       = ch_data[CH_A];
   assign B       = ch_data[CH_B];
   assign C       = ch_data[CH_C];
   assign D       = ch_data[CH_D];
   assign A_valid = ch_valid[CH_A];
   assign B_valid = ch_valid[CH_B];
   assign C_valid = ch_valid[CH_C];
   assign D_valid = ch_valid[CH_D];
   assign busy    = |ch_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux4_16b_buf.sv
//------------------------------------------------------------------------------
// tb_demux4_16b_buf : scoreboard bench for demux4_16b_buf (directed + random)
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux4_16b_buf;

   logic        CLK;
   logic        RST_N;
   logic [15:0] X;
   logic [1:0]  control;
   logic        in_valid;
   logic        in_ready;
   logic        broadcast;
   logic [15:0] A, B, C, D;
   logic        A_valid, B_valid, C_valid, D_valid;
   logic        A_ready, B_ready, C_ready, D_ready;
   logic        busy;

   demux4_16b_buf dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .X         (X),
      .control   (control),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef DEMUX_BROADCAST_EN
      .broadcast (broadcast),
`endif
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .A_valid   (A_valid),
      .B_valid   (B_valid),
      .C_valid   (C_valid),
      .D_valid   (D_valid),
      .A_ready   (A_ready),
      .B_ready   (B_ready),
      .C_ready   (C_ready),
      .D_ready   (D_ready),
      .busy      (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: one FIFO of expected words per channel, plus occupancy flags.
   logic [15:0] exp_q [4][$];
   bit   [3:0]  model_full;

   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] out_data [4];

   assign out_valid   = {D_valid, C_valid, B_valid, A_valid};
   assign out_ready   = {D_ready, C_ready, B_ready, A_ready};
   assign out_data[0] = A;
   assign out_data[1] = B;
   assign out_data[2] = C;
   assign out_data[3] = D;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, predict in_ready, update the model at the edge.
   task automatic step(input logic v, input logic [1:0] c, input logic [15:0] x,
                       input logic [3:0] rdy, input logic bc);
      bit exp_ir;
      in_valid = v;
      control  = c;
      X        = x;
      {D_ready, C_ready, B_ready, A_ready} = rdy;
`ifdef DEMUX_BROADCAST_EN
      broadcast = bc;
`else
      broadcast = 1'b0;
`endif
      @(negedge CLK);
      if (broadcast) begin
         exp_ir = 1'b1;
         for (int k = 0; k < 4; k++)
            if (model_full[k] && !rdy[k]) exp_ir = 1'b0;
      end else begin
         exp_ir = !model_full[c] || rdy[c];
      end
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      @(posedge CLK);
      for (int k = 0; k < 4; k++) begin
         if (v && exp_ir && (broadcast || (int'(c) == k))) begin
            model_full[k] = 1'b1;
            exp_q[k].push_back(x);
         end else if (rdy[k]) begin
            model_full[k] = 1'b0;
         end
      end
      #1;
   endtask

   // Monitor: every channel presenting a word must match the scoreboard head.
   always @(negedge CLK) begin
      bit any;
      any = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (exp_q[k].size() > 0) begin
            any = 1'b1;
            chk($sformatf("valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
            chk($sformatf("data%0d", k), {16'd0, out_data[k]}, {16'd0, exp_q[k][0]});
            if (out_ready[k]) void'(exp_q[k].pop_front());
         end else begin
            chk($sformatf("valid%0d", k), {31'd0, out_valid[k]}, 32'd0);
         end
      end
      chk("busy", {31'd0, busy}, {31'd0, any});
   end

   initial begin
      RST_N     = 1'b0;
      in_valid  = 1'b1;
      X         = 16'hFFFF;
      control   = 2'd0;
      broadcast = 1'b0;
      {D_ready, C_ready, B_ready, A_ready} = 4'h0;
      model_full = '0;

      // Reset with a valid word presented: nothing may load.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_valids", {28'd0, out_valid}, 32'd0);
      chk("rst_A", {16'd0, A}, 32'd0);
      chk("rst_B", {16'd0, B}, 32'd0);
      chk("rst_C", {16'd0, C}, 32'd0);
      chk("rst_D", {16'd0, D}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b0;
      @(posedge CLK);
      #1 RST_N = 1'b1;

      // Steering: each word lands only on its channel one cycle later.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 2'(k), 16'(1 << k), 4'hF, 1'b0);
         chk("steer_onehot", {28'd0, out_valid}, 32'(1 << k));
      end
      step(1'b0, 2'd0, 16'h0, 4'hF, 1'b0);

      // Back-pressure on B, then zero-bubble refill.
      step(1'b1, 2'd1, 16'hAAAA, 4'b1101, 1'b0);
      step(1'b1, 2'd1, 16'h5555, 4'b1101, 1'b0);
      chk("bp_hold_B", {16'd0, B}, 32'h0000_AAAA);
      step(1'b1, 2'd1, 16'h5555, 4'b1111, 1'b0);
      chk("refill_B_valid", {31'd0, B_valid}, 32'd1);
      chk("refill_B", {16'd0, B}, 32'h0000_5555);
      step(1'b0, 2'd0, 16'h0, 4'hF, 1'b0);

      // C stalled does not block D.
      step(1'b1, 2'd2, 16'hC0C0, 4'b1011, 1'b0);
      step(1'b1, 2'd3, 16'h1234, 4'b0011, 1'b0);
      chk("indep_D", {16'd0, D}, 32'h0000_1234);
      chk("indep_C", {16'd0, C}, 32'h0000_C0C0);
      chk("indep_C_valid", {31'd0, C_valid}, 32'd1);

      // Fill all four, then asynchronous reset between edges.
      for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 16'h7000 + 16'(k), 4'h0, 1'b0);
      chk("all_full", {28'd0, out_valid}, 32'hF);
      RST_N = 1'b0;
      #1;
      chk("async_valids", {28'd0, out_valid}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      model_full = '0;
      #1 RST_N = 1'b1;

`ifdef DEMUX_BROADCAST_EN
      // Broadcast blocked by stalled A, then released.
      step(1'b1, 2'd0, 16'hA5A5, 4'b1110, 1'b0);
      step(1'b1, 2'd2, 16'hBEEF, 4'b1110, 1'b1);
      step(1'b1, 2'd2, 16'hBEEF, 4'b1111, 1'b1);
      chk("bcast_all", {28'd0, out_valid}, 32'hF);
      chk("bcast_A", {16'd0, A}, 32'h0000_BEEF);
      chk("bcast_D", {16'd0, D}, 32'h0000_BEEF);
      step(1'b0, 2'd0, 16'h0, 4'hF, 1'b0);
`endif

      // Randomised traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 7) == 0);
      end

      step(1'b0, 2'd0, 16'h0, 4'hF, 1'b0);
      step(1'b0, 2'd0, 16'h0, 4'hF, 1'b0);
      chk("final_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
